button_debounce: RTL and testbench

Two-channel input conditioner in front of the `top` logic on the TinyFPGA board. It synchronises two raw push-button/switch pins to `clk` and debounces each one. It drives clean levels `in_1`/`in_0` into `top`, plus one-cycle rise and fall pulses per channel. Without it, contact bounce and metastability on the board pins reach `top` directly, and `out_0` chatters.

---
 rtl/button_debounce_if.sv | 35 +++
 rtl/button_debounce.sv | 113 +++++++++++
 tb/tb_button_debounce.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - pin and conditioned-level bundle for button_debounce
interface button_debounce_if;
    logic btn_1;
    logic btn_0;
    logic in_1;
    logic in_0;
    logic rise_1;
    logic fall_1;
    logic rise_0;
    logic fall_0;

    // Debouncer side: raw pins in, clean levels and edge pulses out
    modport slave (
        input  btn_1,
        input  btn_0,
        output in_1,
        output in_0,
        output rise_1,
        output fall_1,
        output rise_0,
        output fall_0
    );

    // Board/driver side: drives raw pins, consumes conditioned signals
    modport master (
        output btn_1,
        output btn_0,
        input  in_1,
        input  in_0,
        input  rise_1,
        input  fall_1,
        input  rise_0,
        input  fall_0
    );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-channel synchroniser and debouncer with edge pulses
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int CNT_W           = 14
) (
    input  logic              clk,
    input  logic              rst,
    button_debounce_if.slave  io
);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Acceptance happens on the edge where the counter already holds N-1,
    // so the counter never needs to represent N and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;

    assign btn = {io.btn_1, io.btn_0};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             s1_q;
        logic             s2_q;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        // Two-flop synchroniser for the asynchronous pin; only s2 is used downstream
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= btn[ch];
                s2_q <= s1_q;
            end
        end

        // State, counter, stable level and pulse registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= STABLE;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // Next-state: count consecutive differing samples, reject on any match, accept at N
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            lvl_d   = lvl_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                STABLE: begin
                    if (s2_q != lvl_q) begin
                        state_d = PENDING;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                PENDING: begin
                    if (s2_q == lvl_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                        lvl_d   = s2_q;
                        rise_d  = s2_q;
                        fall_d  = ~s2_q;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign lvl[ch]  = lvl_q;
        assign rise[ch] = rise_q;
        assign fall[ch] = fall_q;
    end

    assign io.in_1   = lvl[1];
    assign io.in_0   = lvl[0];
    assign io.rise_1 = rise[1];
    assign io.fall_1 = fall[1];
    assign io.rise_0 = rise[0];
    assign io.fall_0 = fall[0];

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    button_debounce_if io ();

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {in_1, in_0, rise_1, fall_1, rise_0, fall_0}
    function automatic logic [5:0] obs();
        return {io.in_1, io.in_0, io.rise_1, io.fall_1, io.rise_0, io.fall_0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        io.btn_1 = 1'b0;
        io.btn_0 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        io.btn_1 = 1'b1;
        io.btn_0 = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs() !== 6'b000000) begin
                n_bad++;
                $display("FAIL reset[%0d] outputs got %b want %b", i, obs(), 6'b000000);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {i >= 5, i >= 5, i == 5, 1'b0, i == 5, 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL post_reset_rise edge %0d got %b want %b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_press_release();
        logic [5:0] exp;
        do_reset();
        io.btn_1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {i >= 5, 1'b0, i == 5, 1'b0, 1'b0, 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL press edge %0d got %b want %b", i, obs(), exp);
            end
        end
        io.btn_1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {i < 5, 1'b0, 1'b0, i == 5, 1'b0, 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL release edge %0d got %b want %b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        logic [5:0] exp;
        pat = 8'b1110_1110;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            io.btn_0 = pat[7-k];
            tick();
            n_cmp++;
            if (obs() !== 6'b000000) begin
                n_bad++;
                $display("FAIL bounce step %0d got %b want %b", k, obs(), 6'b000000);
            end
        end
        io.btn_0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {1'b0, i >= 5, 1'b0, 1'b0, i == 5, 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL bounce_settle edge %0d got %b want %b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp;
        do_reset();
        io.btn_1 = 1'b1;
        io.btn_0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {i >= 5, i >= 5, i == 5, 1'b0, i == 5, 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL simultaneous edge %0d got %b want %b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        logic [5:0] exp;
        do_reset();
        io.btn_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (obs() !== 6'b000000) begin
                n_bad++;
                $display("FAIL mid_pending hold %0d got %b want %b", i, obs(), 6'b000000);
            end
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (obs() !== 6'b000000) begin
            n_bad++;
            $display("FAIL mid_pending in_reset got %b want %b", obs(), 6'b000000);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {i >= 5, 1'b0, i == 5, 1'b0, 1'b0, 1'b0};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL mid_pending_recover edge %0d got %b want %b", i, obs(), exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        io.btn_1 = 1'b0;
        io.btn_0 = 1'b0;
        test_reset();
        test_press_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
